// File: rtl/timer_pkg.sv
// Shared encodings, field limits and set-point helpers for the timer/alarm mode controller.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_TIMER = 2'b00,
    MODE_SW    = 2'b01,
    MODE_CLOCK = 2'b10,
    MODE_ALARM = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    T_EDIT  = 2'd0,
    T_RUN   = 2'd1,
    T_PAUSE = 2'd2
  } t_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } s_state_e;

  localparam logic [5:0] FIELD_MAX     = 6'd59;
  localparam int         HOURS_MAX_DEF = 24;

  localparam logic [1:0] CUR_HH  = 2'd0;
  localparam logic [1:0] CUR_MM  = 2'd1;
  localparam logic [1:0] CUR_SS  = 2'd2;
  localparam logic [1:0] CUR_GO  = 2'd3;
  localparam logic [1:0] CUR_ARM = 2'd2;

  // Field increment without carry into the neighbouring field.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
    if (v >= lim) begin
      return 6'd0;
    end else begin
      return v + 6'd1;
    end
  endfunction

  function automatic logic [31:0] to_centis(input logic [4:0] hh, input logic [5:0] mm,
                                            input logic [5:0] ss);
    logic [31:0] secs;
    secs = ({27'd0, hh} * 32'd60 + {26'd0, mm}) * 32'd60 + {26'd0, ss};
    return secs * 32'd100;
  endfunction

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector; press_o is a registered 1-clock pulse.
module button_edge_sync (
  input  logic clockSignal,
  input  logic splitOrReset,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync2_q, prev_q, press_q;

  // Synchronise the raw level and register its rising edge.
  always_ff @(posedge clockSignal or posedge splitOrReset) begin
    if (splitOrReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= sync2_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/timer_mode_controller.sv
// Front-panel sequencer: display modes, timer/stopwatch FSMs, set-points and ring control.
// Optional build macro RING_TIMEOUT_EN: ring auto-stops after RING_CYCLES clocks.
module timer_mode_controller
  import timer_pkg::*;
#(
  parameter int HOURS_MAX   = HOURS_MAX_DEF,
  parameter int CD_W        = 24,
  parameter int RING_CYCLES = 3000
) (
  input  logic            clockSignal,
  input  logic            splitOrReset,
  input  logic            mode_btn,
  input  logic            start_btn,
  input  logic            lap_btn,
  input  logic            cd_zero,
  input  logic            alarm_match,
  output logic [1:0]      mode,
  output logic [1:0]      cursor,
  output logic [4:0]      set_hh,
  output logic [5:0]      set_mm,
  output logic [5:0]      set_ss,
  output logic [4:0]      al_hh,
  output logic [5:0]      al_mm,
  output logic            alarm_armed,
  output logic            cd_run,
  output logic            cd_load,
  output logic [CD_W-1:0] cd_load_value,
  output logic            sw_run,
  output logic            sw_clear,
  output logic            lap_capture,
  output logic            ringSound
);

  localparam logic [5:0] HH_LIM = 6'(HOURS_MAX - 1);

  logic mode_p, start_p, lap_p;
  logic act_dismiss, act_mode, act_start, act_lap;
  logic ring_set, ring_expire;

  mode_e            mode_q, mode_d;
  t_state_e         t_state_q, t_state_d;
  s_state_e         s_state_q, s_state_d;
  logic [1:0]       cursor_q, cursor_d;
  logic [4:0]       set_hh_q, set_hh_d, al_hh_q, al_hh_d;
  logic [5:0]       set_mm_q, set_mm_d, set_ss_q, set_ss_d, al_mm_q, al_mm_d;
  logic             armed_q, armed_d, cd_run_q, cd_run_d, cd_load_q, cd_load_d;
  logic             sw_run_q, sw_run_d, sw_clear_q, sw_clear_d, lap_cap_q, lap_cap_d;
  logic             ring_q, ring_d;
  logic [CD_W-1:0]  cd_val_q, cd_val_d;

  button_edge_sync u_mode_sync  (.clockSignal(clockSignal), .splitOrReset(splitOrReset),
                                 .btn_i(mode_btn),  .press_o(mode_p));
  button_edge_sync u_start_sync (.clockSignal(clockSignal), .splitOrReset(splitOrReset),
                                 .btn_i(start_btn), .press_o(start_p));
  button_edge_sync u_lap_sync   (.clockSignal(clockSignal), .splitOrReset(splitOrReset),
                                 .btn_i(lap_btn),   .press_o(lap_p));

  // One press per cycle: dismiss > mode > start > lap.
  assign act_dismiss = start_p & ring_q;
  assign act_mode    = mode_p & ~act_dismiss;
  assign act_start   = start_p & ~ring_q & ~mode_p;
  assign act_lap     = lap_p & ~mode_p & ~start_p;
  assign ring_set    = ((t_state_q == T_RUN) & cd_run_q & cd_zero) | (alarm_match & armed_q);

`ifdef RING_TIMEOUT_EN
  localparam int RC_W = $clog2(RING_CYCLES + 1);
  logic [RC_W-1:0] ring_cnt_q, ring_cnt_d;

  assign ring_expire = ring_q & (ring_cnt_q == RC_W'(RING_CYCLES - 1));

  always_comb begin
    ring_cnt_d = ring_cnt_q;
    if (ring_set || !ring_q) begin
      ring_cnt_d = '0;
    end else begin
      ring_cnt_d = ring_cnt_q + RC_W'(1);
    end
  end

  always_ff @(posedge clockSignal or posedge splitOrReset) begin
    if (splitOrReset) begin
      ring_cnt_q <= '0;
    end else begin
      ring_cnt_q <= ring_cnt_d;
    end
  end
`else
  logic unused_ring_cfg;
  assign unused_ring_cfg = ^32'(RING_CYCLES);
  assign ring_expire     = 1'b0;
`endif

  always_comb begin
    mode_d    = mode_q;
    t_state_d = t_state_q;
    s_state_d = s_state_q;
    cursor_d  = cursor_q;
    set_hh_d  = set_hh_q;
    set_mm_d  = set_mm_q;
    set_ss_d  = set_ss_q;
    al_hh_d   = al_hh_q;
    al_mm_d   = al_mm_q;
    armed_d   = armed_q;
    cd_run_d  = cd_run_q;
    cd_load_d = 1'b0;
    sw_run_d  = sw_run_q;
    sw_clear_d = 1'b0;
    lap_cap_d = 1'b0;
    cd_val_d  = CD_W'(to_centis(set_hh_q, set_mm_q, set_ss_q));

    if (act_mode) begin
      mode_d   = mode_e'(mode_q + 2'd1);
      cursor_d = CUR_HH;
    end else begin
      mode_d = mode_q;
    end

    // Timer FSM runs whatever mode is displayed; presses only reach it in TIMER mode.
    case (t_state_q)
      T_EDIT: begin
        cd_run_d = 1'b0;
        if (act_start && mode_q == MODE_TIMER) begin
          case (cursor_q)
            CUR_HH: set_hh_d = 5'(inc_wrap({1'b0, set_hh_q}, HH_LIM));
            CUR_MM: set_mm_d = inc_wrap(set_mm_q, FIELD_MAX);
            CUR_SS: set_ss_d = inc_wrap(set_ss_q, FIELD_MAX);
            CUR_GO: begin
              if (set_hh_q != 5'd0 || set_mm_q != 6'd0 || set_ss_q != 6'd0) begin
                cd_load_d = 1'b1;
                t_state_d = T_RUN;
              end else begin
                t_state_d = T_EDIT;
              end
            end
            default: cursor_d = CUR_HH;
          endcase
        end else if (act_lap && mode_q == MODE_TIMER) begin
          cursor_d = cursor_q + 2'd1;
        end else begin
          t_state_d = T_EDIT;
        end
      end
      T_RUN: begin
        if (cd_run_q && cd_zero) begin
          cd_run_d  = 1'b0;
          t_state_d = T_EDIT;
        end else if (act_start && mode_q == MODE_TIMER) begin
          cd_run_d  = 1'b0;
          t_state_d = T_PAUSE;
        end else if (act_lap && mode_q == MODE_TIMER) begin
          cd_run_d  = 1'b0;
          t_state_d = T_EDIT;
          cursor_d  = CUR_HH;
        end else begin
          cd_run_d = 1'b1;
        end
      end
      T_PAUSE: begin
        if (act_start && mode_q == MODE_TIMER) begin
          cd_run_d  = 1'b1;
          t_state_d = T_RUN;
        end else if (act_lap && mode_q == MODE_TIMER) begin
          cd_run_d  = 1'b0;
          t_state_d = T_EDIT;
          cursor_d  = CUR_HH;
        end else begin
          cd_run_d = 1'b0;
        end
      end
      default: begin
        cd_run_d  = 1'b0;
        t_state_d = T_EDIT;
      end
    endcase

    case (s_state_q)
      S_IDLE, S_STOP: begin
        if (act_start && mode_q == MODE_SW) begin
          sw_run_d  = 1'b1;
          s_state_d = S_RUN;
        end else if (act_lap && mode_q == MODE_SW && s_state_q == S_STOP) begin
          sw_clear_d = 1'b1;
          s_state_d  = S_IDLE;
        end else begin
          sw_run_d = 1'b0;
        end
      end
      S_RUN: begin
        if (act_start && mode_q == MODE_SW) begin
          sw_run_d  = 1'b0;
          s_state_d = S_STOP;
        end else if (act_lap && mode_q == MODE_SW) begin
          lap_cap_d = 1'b1;
        end else begin
          sw_run_d = 1'b1;
        end
      end
      default: begin
        sw_run_d  = 1'b0;
        s_state_d = S_IDLE;
      end
    endcase

    if (mode_q == MODE_ALARM && act_lap) begin
      cursor_d = (cursor_q >= CUR_ARM) ? CUR_HH : cursor_q + 2'd1;
    end else if (mode_q == MODE_ALARM && act_start) begin
      case (cursor_q)
        CUR_HH:  al_hh_d = 5'(inc_wrap({1'b0, al_hh_q}, HH_LIM));
        CUR_MM:  al_mm_d = inc_wrap(al_mm_q, FIELD_MAX);
        CUR_ARM: armed_d = ~armed_q;
        default: cursor_d = CUR_HH;
      endcase
    end else begin
      armed_d = armed_q;
    end

    if (act_dismiss) begin
      ring_d = 1'b0;
    end else if (ring_set) begin
      ring_d = 1'b1;
    end else if (ring_expire) begin
      ring_d = 1'b0;
    end else begin
      ring_d = ring_q;
    end
  end

  always_ff @(posedge clockSignal or posedge splitOrReset) begin
    if (splitOrReset) begin
      mode_q    <= MODE_TIMER;
      t_state_q <= T_EDIT;
      s_state_q <= S_IDLE;
      cursor_q  <= 2'd0;
      set_hh_q  <= 5'd0;
      set_mm_q  <= 6'd0;
      set_ss_q  <= 6'd0;
      al_hh_q   <= 5'd0;
      al_mm_q   <= 6'd0;
      armed_q   <= 1'b0;
      cd_run_q  <= 1'b0;
      cd_load_q <= 1'b0;
      cd_val_q  <= '0;
      sw_run_q  <= 1'b0;
      sw_clear_q <= 1'b0;
      lap_cap_q <= 1'b0;
      ring_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      t_state_q <= t_state_d;
      s_state_q <= s_state_d;
      cursor_q  <= cursor_d;
      set_hh_q  <= set_hh_d;
      set_mm_q  <= set_mm_d;
      set_ss_q  <= set_ss_d;
      al_hh_q   <= al_hh_d;
      al_mm_q   <= al_mm_d;
      armed_q   <= armed_d;
      cd_run_q  <= cd_run_d;
      cd_load_q <= cd_load_d;
      cd_val_q  <= cd_val_d;
      sw_run_q  <= sw_run_d;
      sw_clear_q <= sw_clear_d;
      lap_cap_q <= lap_cap_d;
      ring_q    <= ring_d;
    end
  end

  assign mode          = mode_q;
  assign cursor        = cursor_q;
  assign set_hh        = set_hh_q;
  assign set_mm        = set_mm_q;
  assign set_ss        = set_ss_q;
  assign al_hh         = al_hh_q;
  assign al_mm         = al_mm_q;
  assign alarm_armed   = armed_q;
  assign cd_run        = cd_run_q;
  assign cd_load       = cd_load_q;
  assign cd_load_value = cd_val_q;
  assign sw_run        = sw_run_q;
  assign sw_clear      = sw_clear_q;
  assign lap_capture   = lap_cap_q;
  assign ringSound     = ring_q;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Directed bench for timer_mode_controller; follows RING_TIMEOUT_EN like the design.
module tb_timer_mode_controller;

  localparam int RING_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_btn, start_btn, lap_btn, cd_zero, alarm_match;
  logic [1:0]  mode, cursor;
  logic [4:0]  set_hh, al_hh;
  logic [5:0]  set_mm, set_ss, al_mm;
  logic        alarm_armed, cd_run, cd_load, sw_run, sw_clear, lap_capture, ringSound;
  logic [23:0] cd_load_value;

  int n_tests = 0;
  int n_fail  = 0;
  int n_load  = 0;
  int n_lapc  = 0;
  int n_clr   = 0;
  int snap_load, snap_lapc, snap_clr;

  timer_mode_controller #(.HOURS_MAX(24), .CD_W(24), .RING_CYCLES(RING_CYCLES)) dut (
    .clockSignal(clk), .splitOrReset(rst),
    .mode_btn(mode_btn), .start_btn(start_btn), .lap_btn(lap_btn),
    .cd_zero(cd_zero), .alarm_match(alarm_match),
    .mode(mode), .cursor(cursor), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .al_hh(al_hh), .al_mm(al_mm), .alarm_armed(alarm_armed),
    .cd_run(cd_run), .cd_load(cd_load), .cd_load_value(cd_load_value),
    .sw_run(sw_run), .sw_clear(sw_clear), .lap_capture(lap_capture), .ringSound(ringSound)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cd_load)     n_load <= n_load + 1;
    if (lap_capture) n_lapc <= n_lapc + 1;
    if (sw_clear)    n_clr  <= n_clr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hold the level long enough for its effect to register, then let the synchroniser drain.
  task automatic press(input logic m, input logic s, input logic l);
    @(negedge clk);
    mode_btn = m; start_btn = s; lap_btn = l;
    repeat (4) @(negedge clk);
    mode_btn = 1'b0; start_btn = 1'b0; lap_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic presses(input int n, input logic m, input logic s, input logic l);
    for (int i = 0; i < n; i++) press(m, s, l);
  endtask

  task automatic pulse_alarm();
    @(negedge clk);
    alarm_match = 1'b1;
    @(negedge clk);
    alarm_match = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mode"}, 32'(mode), 32'd0);
    chk({tag, "_cursor"}, 32'(cursor), 32'd0);
    chk({tag, "_set"}, 32'({set_hh, set_mm, set_ss}), 32'd0);
    chk({tag, "_alarm"}, 32'({al_hh, al_mm, alarm_armed}), 32'd0);
    chk({tag, "_strobes"}, 32'({cd_run, cd_load, sw_run, sw_clear, lap_capture}), 32'd0);
    chk({tag, "_cdval"}, 32'(cd_load_value), 32'd0);
    chk({tag, "_ring"}, 32'(ringSound), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mode_btn = 1'b0; start_btn = 1'b0; lap_btn = 1'b0;
    cd_zero = 1'b0; alarm_match = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");

    // Timer: 00:00:05 countdown, ring on zero, dismiss.
    presses(2, 1'b0, 1'b0, 1'b1);
    chk("t_cursor_ss", 32'(cursor), 32'd2);
    presses(5, 1'b0, 1'b1, 1'b0);
    chk("t_ss5", 32'(set_ss), 32'd5);
    chk("t_cdval500", 32'(cd_load_value), 32'd500);
    press(1'b0, 1'b0, 1'b1);
    chk("t_cursor_go", 32'(cursor), 32'd3);
    snap_load = n_load;
    press(1'b0, 1'b1, 1'b0);
    chk("t_load_once", 32'(n_load - snap_load), 32'd1);
    chk("t_cd_run", 32'(cd_run), 32'd1);
    cd_zero = 1'b1;
    @(negedge clk);
    cd_zero = 1'b0;
    chk("t_zero_run", 32'(cd_run), 32'd0);
    chk("t_zero_ring", 32'(ringSound), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    chk("t_dismiss_ring", 32'(ringSound), 32'd0);
    chk("t_dismiss_run", 32'(cd_run), 32'd0);
    chk("t_dismiss_noload", 32'(n_load - snap_load), 32'd1);

    // Wrap rules, HH then MM.
    press(1'b0, 1'b0, 1'b1);
    chk("w_cursor_hh", 32'(cursor), 32'd0);
    presses(23, 1'b0, 1'b1, 1'b0);
    chk("w_hh23", 32'(set_hh), 32'd23);
    press(1'b0, 1'b1, 1'b0);
    chk("w_hh_wrap", 32'(set_hh), 32'd0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    presses(59, 1'b0, 1'b1, 1'b0);
    chk("w_mm59", 32'(set_mm), 32'd59);
    press(1'b0, 1'b1, 1'b0);
    chk("w_mm_wrap", 32'(set_mm), 32'd0);
    chk("w_hh_kept", 32'(set_hh), 32'd1);
    chk("w_cdval", 32'(cd_load_value), 32'd360500);

    // Stopwatch.
    press(1'b1, 1'b0, 1'b0);
    chk("s_mode", 32'(mode), 32'd1);
    snap_lapc = n_lapc; snap_clr = n_clr;
    press(1'b0, 1'b0, 1'b1);
    chk("s_idle_lap", 32'({sw_run, 8'(n_lapc - snap_lapc), 8'(n_clr - snap_clr)}), 32'd0);
    press(1'b0, 1'b1, 1'b0);
    chk("s_run_on", 32'(sw_run), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    chk("s_lapcap", 32'(n_lapc - snap_lapc), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    chk("s_run_off", 32'(sw_run), 32'd0);
    press(1'b0, 1'b0, 1'b1);
    chk("s_clear", 32'(n_clr - snap_clr), 32'd1);
    chk("s_lapcap_kept", 32'(n_lapc - snap_lapc), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    chk("s_idle_again", 32'({8'(n_lapc - snap_lapc), 8'(n_clr - snap_clr)}), 32'h0101);

    // Priority: dismiss beats mode; mode beats start.
    presses(2, 1'b1, 1'b0, 1'b0);
    chk("p_mode_alarm", 32'(mode), 32'd3);
    presses(2, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    chk("p_armed", 32'(alarm_armed), 32'd1);
    pulse_alarm();
    chk("p_ring", 32'(ringSound), 32'd1);
    press(1'b1, 1'b1, 1'b0);
    chk("p_dismiss_ring", 32'(ringSound), 32'd0);
    chk("p_dismiss_mode", 32'(mode), 32'd3);
    chk("p_dismiss_armed", 32'(alarm_armed), 32'd1);
    press(1'b1, 1'b1, 1'b0);
    chk("p_mode_only", 32'(mode), 32'd0);
    chk("p_mode_armed", 32'(alarm_armed), 32'd1);
    chk("p_mode_hh", 32'(set_hh), 32'd1);

    // Alarm 07:30 ring and optional timeout.
    presses(3, 1'b1, 1'b0, 1'b0);
    presses(7, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    presses(30, 1'b0, 1'b1, 1'b0);
    chk("a_time", 32'({al_hh, al_mm}), 32'({5'd7, 6'd30}));
    pulse_alarm();
    chk("a_ring", 32'(ringSound), 32'd1);
    repeat (RING_CYCLES - 1) @(negedge clk);
    chk("a_ring_hold", 32'(ringSound), 32'd1);
    @(negedge clk);
`ifdef RING_TIMEOUT_EN
    chk("a_ring_timeout", 32'(ringSound), 32'd0);
`else
    chk("a_ring_stays", 32'(ringSound), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    chk("a_ring_dismiss", 32'(ringSound), 32'd0);
`endif

    // Asynchronous reset with the stopwatch running and the buzzer on.
    presses(2, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    pulse_alarm();
    chk("r_pre", 32'({sw_run, ringSound}), 32'd3);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("r_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // GO with an all-zero set-point does nothing.
    presses(3, 1'b0, 1'b0, 1'b1);
    chk("z_cursor_go", 32'(cursor), 32'd3);
    snap_load = n_load;
    press(1'b0, 1'b1, 1'b0);
    chk("z_noload", 32'(n_load - snap_load), 32'd0);
    chk("z_norun", 32'(cd_run), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
